// File: rtl/c_element_pkg.sv
// Next-state equations shared by the C-element bank.
// Each function maps one lane's inputs plus its current state to its next state.
package c_element_pkg;

   localparam int SYNC_STAGES_DEF = 2;

   // Plain 2-input C: the output follows the inputs when they agree, else it holds.
   function automatic logic c2_next(input logic a, input logic b, input logic q);
      return (a & b) | (q & (a | b));
   endfunction

   // bn is only a name for the sense of the input; the equation is the same as c2.
   function automatic logic c2n_next(input logic a, input logic bn, input logic q);
      return (a & bn) | (q & (a | bn));
   endfunction

   // bn and cn gate only the rise; a low on a clears unconditionally.
   function automatic logic c3n2_next(input logic a, input logic bn, input logic cn,
                                      input logic q);
      return a & ((~bn & ~cn) | q);
   endfunction

endpackage

// File: rtl/c_element_sync.sv
// Reset-clear shift-register synchroniser that brings a vector into the CLK_IN domain.
module c_element_sync
   import c_element_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK_IN,
   input  logic             RESET_IN,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] pipe;

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) pipe <= '0;
      else          pipe <= {pipe[STAGES-2:0], d};
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/c_element_bank.sv
// Bank of WIDTH-lane Muller C-element variants (cel, cel_n, cel3_n2),
// with CLK_IN-domain monitor copies of every output.
module c_element_bank
   import c_element_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter bit SYNC_IMPL   = 1'b1,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             CLK_IN,
   input  logic             RESET_IN,
   input  logic [WIDTH-1:0] c_a,
   input  logic [WIDTH-1:0] c_b,
   output logic [WIDTH-1:0] c_o,
   input  logic [WIDTH-1:0] n_a,
   input  logic [WIDTH-1:0] n_bn,
   output logic [WIDTH-1:0] n_o,
   input  logic [WIDTH-1:0] t_a,
   input  logic [WIDTH-1:0] t_bn,
   input  logic [WIDTH-1:0] t_cn,
   output logic [WIDTH-1:0] t_o,
   output logic [WIDTH-1:0] c_o_sync,
   output logic [WIDTH-1:0] n_o_sync,
   output logic [WIDTH-1:0] t_o_sync
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic c_q, n_q, t_q;

      if (SYNC_IMPL) begin : g_sync
         always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
               c_q <= 1'b0;
               n_q <= 1'b0;
               t_q <= 1'b0;
            end else begin
               c_q <= c2_next(c_a[i], c_b[i], c_q);
               n_q <= c2n_next(n_a[i], n_bn[i], n_q);
               t_q <= c3n2_next(t_a[i], t_bn[i], t_cn[i], t_q);
            end
         end
      end else begin : g_async
         // Intentional latches: transparent whenever a set or clear condition
         // holds (the output then equals a), opaque otherwise, so the state is
         // held without a combinational feedback path.
         always_latch begin
            if (RESET_IN)                  c_q <= 1'b0;
            else if (c_a[i] ~^ c_b[i])     c_q <= c_a[i];
         end

         always_latch begin
            if (RESET_IN)                  n_q <= 1'b0;
            else if (n_a[i] ~^ n_bn[i])    n_q <= n_a[i];
         end

         always_latch begin
            if (RESET_IN)                              t_q <= 1'b0;
            else if (!t_a[i] || (!t_bn[i] && !t_cn[i])) t_q <= t_a[i];
         end
      end

      assign c_o[i] = c_q;
      assign n_o[i] = n_q;
      assign t_o[i] = t_q;
   end

   c_element_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_c_sync (
      .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .d(c_o), .q(c_o_sync));

   c_element_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_n_sync (
      .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .d(n_o), .q(n_o_sync));

   c_element_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_t_sync (
      .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .d(t_o), .q(t_o_sync));

endmodule

// File: tb/tb_c_element_bank.sv
// Directed bench: a clocked 4-lane bank checked against a hand-computed vector
// table and corner sequences, plus a 1-lane level-sensitive bank.
module tb_c_element_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       fb;
   logic [3:0] c_a, c_b, c_b_drv, n_a, n_bn, t_a, t_bn, t_cn;
   logic [3:0] c_o, n_o, t_o, c_o_sync, n_o_sync, t_o_sync;

   logic ac_a, ac_b, an_a, an_bn, at_a, at_bn, at_cn;
   logic ac_o, an_o, at_o, ac_os, an_os, at_os;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Feedback mode closes cel lane b onto the inverted output.
   assign c_b = fb ? ~c_o : c_b_drv;

   c_element_bank #(.WIDTH(4), .SYNC_IMPL(1'b1), .SYNC_STAGES(2)) dut (
      .CLK_IN(clk), .RESET_IN(rst),
      .c_a(c_a), .c_b(c_b), .c_o(c_o),
      .n_a(n_a), .n_bn(n_bn), .n_o(n_o),
      .t_a(t_a), .t_bn(t_bn), .t_cn(t_cn), .t_o(t_o),
      .c_o_sync(c_o_sync), .n_o_sync(n_o_sync), .t_o_sync(t_o_sync));

   c_element_bank #(.WIDTH(1), .SYNC_IMPL(1'b0), .SYNC_STAGES(2)) dut_async (
      .CLK_IN(clk), .RESET_IN(rst),
      .c_a(ac_a), .c_b(ac_b), .c_o(ac_o),
      .n_a(an_a), .n_bn(an_bn), .n_o(an_o),
      .t_a(at_a), .t_bn(at_bn), .t_cn(at_cn), .t_o(at_o),
      .c_o_sync(ac_os), .n_o_sync(an_os), .t_o_sync(at_os));

   typedef struct {
      logic [3:0] ca, cb, na, nbn, ta, tbn, tcn;
      logic [3:0] ec, en, et;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          ca    cb    na    nbn   ta    tbn   tcn   ec    en    et
      vecs[0] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
      vecs[1] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
      vecs[2] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
      vecs[3] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0};
      vecs[4] = '{4'hA, 4'hC, 4'h0, 4'h0, 4'hF, 4'h5, 4'h3, 4'h8, 4'h0, 4'h8};
      vecs[5] = '{4'h6, 4'h3, 4'hC, 4'h5, 4'hE, 4'hF, 4'hF, 4'h2, 4'h4, 4'h8};
      vecs[6] = '{4'hF, 4'hF, 4'h0, 4'h4, 4'h7, 4'h0, 4'h0, 4'hF, 4'h4, 4'h7};
      vecs[7] = '{4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0};

      // Reset held with every set condition true.
      fb = 1'b0; rst = 1'b1;
      c_a = 4'hF; c_b_drv = 4'hF; n_a = 4'hF; n_bn = 4'hF;
      t_a = 4'hF; t_bn = 4'h0; t_cn = 4'h0;
      ac_a = 1'b1; ac_b = 1'b1; an_a = 1'b1; an_bn = 1'b1;
      at_a = 1'b1; at_bn = 1'b0; at_cn = 1'b0;
      repeat (2) tick();
      check("rst_c_o", c_o, 4'h0);
      check("rst_n_o", n_o, 4'h0);
      check("rst_t_o", t_o, 4'h0);
      check("rst_c_sync", c_o_sync, 4'h0);
      check("rst_n_sync", n_o_sync, 4'h0);
      check("rst_t_sync", t_o_sync, 4'h0);
      check("rst_async_c", {3'b0, ac_o}, 4'h0);
      check("rst_async_t", {3'b0, at_o}, 4'h0);
      ac_a = 1'b0; ac_b = 1'b0; an_a = 1'b0; an_bn = 1'b0; at_a = 1'b0;

      rst = 1'b0;
      tick();
      check("rel_c_o", c_o, 4'hF);
      check("rel_n_o", n_o, 4'hF);
      check("rel_t_o", t_o, 4'hF);
      check("rel_c_sync_1", c_o_sync, 4'h0);
      tick();
      check("rel_c_sync_2", c_o_sync, 4'h0);
      tick();
      check("rel_c_sync_3", c_o_sync, 4'hF);
      check("rel_n_sync_3", n_o_sync, 4'hF);
      check("rel_t_sync_3", t_o_sync, 4'hF);

      // Clear everything, then run the vector table.
      c_a = 4'h0; c_b_drv = 4'h0; n_a = 4'h0; n_bn = 4'h0; t_a = 4'h0;
      tick();
      check("clr_all", c_o | n_o | t_o, 4'h0);

      for (int i = 0; i < 8; i++) begin
         c_a = vecs[i].ca; c_b_drv = vecs[i].cb;
         n_a = vecs[i].na; n_bn = vecs[i].nbn;
         t_a = vecs[i].ta; t_bn = vecs[i].tbn; t_cn = vecs[i].tcn;
         tick();
         check($sformatf("vec%0d_c_o", i), c_o, vecs[i].ec);
         check($sformatf("vec%0d_n_o", i), n_o, vecs[i].en);
         check($sformatf("vec%0d_t_o", i), t_o, vecs[i].et);
      end

      // Output fed back to its own b input: follows a with one cycle latency, no oscillation.
      fb = 1'b1; c_a = 4'h0;
      tick();
      check("fb_init", c_o, 4'h0);
      foreach (vecs[k]) begin
         logic r;
         r = k[0] ^ k[1];
         c_a = {4{r}};
         tick();
         check($sformatf("fb%0d_follow", k), c_o, {4{r}});
         tick();
         check($sformatf("fb%0d_stable", k), c_o, {4{r}});
      end
      fb = 1'b0;

      // Level-sensitive bank: zero clock latency, checked between edges.
      ac_a = 1'b1; ac_b = 1'b1; #1 check("as_c_set", {3'b0, ac_o}, 4'h1);
      ac_a = 1'b0;              #1 check("as_c_hold", {3'b0, ac_o}, 4'h1);
      ac_b = 1'b0;              #1 check("as_c_clr", {3'b0, ac_o}, 4'h0);
      ac_a = 1'b1;              #1 check("as_c_hold0", {3'b0, ac_o}, 4'h0);
      an_a = 1'b1; an_bn = 1'b1; #1 check("as_n_set", {3'b0, an_o}, 4'h1);
      an_a = 1'b0;               #1 check("as_n_latch", {3'b0, an_o}, 4'h1);
      an_bn = 1'b0;              #1 check("as_n_clr", {3'b0, an_o}, 4'h0);
      at_a = 1'b1; at_bn = 1'b1; at_cn = 1'b0; #1 check("as_t_gated", {3'b0, at_o}, 4'h0);
      at_bn = 1'b0;              #1 check("as_t_set", {3'b0, at_o}, 4'h1);
      at_cn = 1'b1;              #1 check("as_t_hold", {3'b0, at_o}, 4'h1);
      at_bn = 1'b1;              #1 check("as_t_hold2", {3'b0, at_o}, 4'h1);
      at_a = 1'b0;               #1 check("as_t_clr", {3'b0, at_o}, 4'h0);
      ac_b = 1'b1;               #1 check("as_c_set2", {3'b0, ac_o}, 4'h1);

      // Mid-operation asynchronous reset pulse with lanes at 1011.
      tick();
      c_a = 4'hB; c_b_drv = 4'hB;
      tick();
      check("mid_pre", c_o, 4'hB);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_c_o", c_o, 4'h0);
      check("mid_rst_c_sync", c_o_sync, 4'h0);
      check("mid_rst_async", {3'b0, ac_o}, 4'h0);
      c_b_drv = 4'h0;
      rst = 1'b0;
      #1 check("mid_rel_async", {3'b0, ac_o}, 4'h1);
      tick();
      check("mid_hold0", c_o, 4'h0);
      c_a = 4'h1; c_b_drv = 4'h1;
      tick();
      check("mid_lane0", c_o, 4'h1);
      c_a = 4'h1; c_b_drv = 4'h4;
      tick();
      check("mid_indep", c_o, 4'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/c_element_bank.md
Name: c_element_bank

Overview:
- Bank of Muller C-element variants for the SpiNNaker-link async handshake logic: a plain 2-input C (cel), a 2-input C with active-low-named second input (cel_n), and an asymmetric 3-input C with two inverted set-inputs (cel3_n2).
- Each variant is a WIDTH-wide vector of independent lanes.
- Also provides CLK_IN-synchronised copies of all outputs for sync-domain monitoring.
- Usable as a clocked FPGA-safe emulation when SYNC_IMPL=1.

Parameters:
- WIDTH, 1, number of independent lanes per variant.
- SYNC_IMPL, 1, 1 = state registers update on CLK_IN; 0 = level-sensitive asynchronous state hold.
- SYNC_STAGES, 2, flip-flop stages in the monitor synchronisers (min 2).

Ports:
- CLK_IN  in  1  clock for SYNC_IMPL=1 state and for the monitor synchronisers.
- RESET_IN  in  1  asynchronous, active-high reset for all lanes.
- c_a  in  WIDTH  cel input a.
- c_b  in  WIDTH  cel input b.
- c_o  out  WIDTH  cel output.
- n_a  in  WIDTH  cel_n input a.
- n_bn  in  WIDTH  cel_n input bn.
- n_o  out  WIDTH  cel_n output.
- t_a  in  WIDTH  cel3_n2 input a.
- t_bn  in  WIDTH  cel3_n2 input bn (inverted sense).
- t_cn  in  WIDTH  cel3_n2 input cn (inverted sense).
- t_o  out  WIDTH  cel3_n2 output.
- c_o_sync  out  WIDTH  c_o synchronised to CLK_IN.
- n_o_sync  out  WIDTH  n_o synchronised to CLK_IN.
- t_o_sync  out  WIDTH  t_o synchronised to CLK_IN.

Behaviour:
- Reset: RESET_IN=1 forces every output and every synchroniser stage to 0, immediately (asynchronous) and for as long as it is held. Reset dominates any set condition. Release resumes evaluation from state 0.
- cel, per lane:
  - set when a=1 and b=1;
  - clear when a=0 and b=0;
  - otherwise hold.
- cel_n, per lane:
  - set when a=1 and bn=1;
  - clear when a=0 and bn=0;
  - otherwise hold.
  - Intended use is bn=~reset_like, so the output latches the first assertion of a and stays high until both drop.
- cel3_n2, per lane:
  - set when a=1, bn=0 and cn=0;
  - clear when a=0, regardless of bn and cn;
  - otherwise hold.
  - bn and cn gate only the rising transition.
- SYNC_IMPL=1:
  - next-state is computed combinationally from the inputs and the current state;
  - the state register updates on the CLK_IN rising edge, so the output changes exactly 1 cycle after its condition is sampled;
  - no combinational loops; an output fed back to its own input is legal.
- SYNC_IMPL=0:
  - output follows its condition with zero clock latency;
  - the hold is implemented as feedback (o = set | (o & ~clr)), marked as an intentional latch.
- Monitor outputs: *_o_sync is the SYNC_STAGES-flop copy of *_o. Latency is SYNC_STAGES cycles after *_o changes (after the state update in SYNC_IMPL=1).
- Lanes never interact. Input glitches that do not meet a set or clear condition leave the state unchanged.

Decomposition:
- Shared package c_element_pkg: SYNC_STAGES default and the next-state functions c2_next, c2n_next and c3n2_next (inputs plus current state in, next state out).
- One natural sub-module: c_element_sync, a per-vector SYNC_STAGES-deep reset-clear synchroniser, instantiated three times.

Test Plan:
- Reset, WIDTH=1, SYNC_IMPL=1: hold RESET_IN=1 with all set conditions true → all outputs 0. Release → c_o, n_o, t_o =1 one cycle later; *_o_sync =1 after 2 further cycles.
- cel hold: a=1,b=1 → c_o=1; a=0,b=1 → stays 1; a=0,b=0 → 0 next cycle; a=1,b=0 → stays 0.
- cel_n latch: bn=1, pulse a=1 for one cycle → n_o=1 and stays 1 with a=0. Drop bn=0 with a=0 → n_o=0.
- cel3_n2 gating:
  - a=1, bn=1, cn=0 → t_o stays 0;
  - bn→0 → t_o=1;
  - cn→1 → t_o holds 1;
  - a→0 → t_o=0 even with bn=cn=1.
- Feedback loop (cel a=r, b=~c_o), toggle r: c_o follows r with 1-cycle latency and never oscillates.
- Mid-operation reset, WIDTH=4, lanes at o=4'b1011: RESET_IN pulse → all 0 asynchronously; other lanes unaffected by per-lane stimuli afterwards.
